// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// riscv_pkg : shared encodings and forwarding helper for the hazard controller
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_e;

    // MEM wins over WB because it holds the younger result; x0 is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       wr_m,
        input logic [4:0] rd_w,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_MEM;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// hazard_if : pipeline <-> hazard controller signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface hazard_if;

    logic [4:0]  Rs1D, Rs2D;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [4:0]  RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE;
    logic        mem_req_M;
    logic        mem_ready;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic        mem_abort;
    logic [31:0] stall_cycles, flush_events;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, mem_req_M, mem_ready,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, mem_abort, stall_cycles, flush_events
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, mem_req_M, mem_ready,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, mem_abort, stall_cycles, flush_events
    );

endinterface

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_unit.sv
// ============================================================================
// hazard_fwd_unit : combinational forwarding selects for both EX operands
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_unit
    import riscv_pkg::*;
(
    input  wire logic [4:0] Rs1E_i,
    input  wire logic [4:0] Rs2E_i,
    input  wire logic [4:0] RdM_i,
    input  wire logic [4:0] RdW_i,
    input  wire logic       RegWriteM_i,
    input  wire logic       RegWriteW_i,
    output logic      [1:0] ForwardAE_o,
    output logic      [1:0] ForwardBE_o
);

    assign ForwardAE_o = fwd_select(Rs1E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);
    assign ForwardBE_o = fwd_select(Rs2E_i, RdM_i, RegWriteM_i, RdW_i, RegWriteW_i);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : forwarding, stall/flush control and data-memory wait FSM
// Optional perf counters enabled by HAZARD_PERF_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  wire logic clock,
    input  wire logic reset_n,
    hazard_if.slave   hz
);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       lw_stall, timeout, mem_stall;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w, abort;

    hazard_fwd_unit u_fwd (
        .Rs1E_i      (hz.Rs1E),
        .Rs2E_i      (hz.Rs2E),
        .RdM_i       (hz.RdM),
        .RdW_i       (hz.RdW),
        .RegWriteM_i (hz.RegWriteM),
        .RegWriteW_i (hz.RegWriteW),
        .ForwardAE_o (fwd_a),
        .ForwardBE_o (fwd_b)
    );

    assign lw_stall = (hz.ResultSrcE == RESULT_LOAD) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    assign timeout  = (state_q == WAIT) && !hz.mem_ready &&
                      (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // A dropped mem_req_M in WAIT is ignored: only mem_ready or timeout leaves.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (hz.mem_req_M && !hz.mem_ready) begin
                    state_d    = WAIT;
                    wait_cnt_d = CNT_W'(1);
                end
            end
            WAIT: begin
                if (hz.mem_ready || timeout) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        abort     = 1'b0;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        flush_w   = 1'b0;
        if (reset_n) begin
            if (state_q == RUN) begin
                mem_stall = hz.mem_req_M && !hz.mem_ready;
            end else begin
                mem_stall = !hz.mem_ready && !timeout;
            end
            abort = timeout;
            if (mem_stall) begin
                // EX is frozen, so load-use and branch redirects wait their turn.
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else begin
                stall_f = lw_stall;
                stall_d = lw_stall;
                flush_d = hz.PCSrcE;
                flush_e = lw_stall | hz.PCSrcE;
                flush_w = abort;
            end
        end
    end

    assign hz.ForwardAE = reset_n ? fwd_a : FWD_REG;
    assign hz.ForwardBE = reset_n ? fwd_b : FWD_REG;
    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_d;
    assign hz.StallE    = stall_e;
    assign hz.StallM    = stall_m;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.FlushW    = flush_w;
    assign hz.mem_abort = abort;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_f && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_e && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_cycles = stall_cnt_q;
    assign hz.flush_events = flush_cnt_q;
`else
    assign hz.stall_cycles = '0;
    assign hz.flush_events = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : directed self-checking bench for hazard_ctrl (TIMEOUT=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic clock;
    logic reset_n;
    int   nvec;
    int   nerr;

    hazard_if hz ();

    hazard_ctrl #(.TIMEOUT(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (hz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,mem_abort}
    logic [7:0] ctl;
    assign ctl = {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                  hz.FlushD, hz.FlushE, hz.FlushW, hz.mem_abort};

    task automatic clear_inputs();
        hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
        hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
        hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0; hz.ResultSrcE = 2'b00;
        hz.PCSrcE = 1'b0; hz.mem_req_M = 1'b0; hz.mem_ready = 1'b0;
    endtask

    task automatic cycle();
        @(negedge clock);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd3; hz.Rs1D = 5'd3;
        hz.PCSrcE = 1'b1; hz.mem_req_M = 1'b1;
        #12;
        nvec++;
        if (ctl !== 8'h00) begin
            $display("FAIL reset_ctl got=%b exp=%b", ctl, 8'h00); nerr++;
        end
        nvec++;
        if (hz.ForwardAE !== 2'b00) begin
            $display("FAIL reset_fwdA got=%b exp=00", hz.ForwardAE); nerr++;
        end
        nvec++;
        if ((hz.stall_cycles !== 32'd0) || (hz.flush_events !== 32'd0)) begin
            $display("FAIL reset_perf got=%0d/%0d exp=0/0", hz.stall_cycles, hz.flush_events); nerr++;
        end
        cycle();
        clear_inputs();
        reset_n = 1'b1;
        cycle();
    endtask

    task automatic test_forwarding();
        clear_inputs();
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1;
        hz.RdW = 5'd5; hz.RegWriteW = 1'b1; hz.Rs2E = 5'd6;
        #2;
        nvec++;
        if (hz.ForwardAE !== 2'b10) begin
            $display("FAIL fwd_mem_prio got=%b exp=10", hz.ForwardAE); nerr++;
        end
        nvec++;
        if (hz.ForwardBE !== 2'b00) begin
            $display("FAIL fwdB_nomatch got=%b exp=00", hz.ForwardBE); nerr++;
        end
        cycle();
        hz.RdM = 5'd0;
        #2;
        nvec++;
        if (hz.ForwardAE !== 2'b01) begin
            $display("FAIL fwd_rdm_zero got=%b exp=01", hz.ForwardAE); nerr++;
        end
        cycle();
        hz.RdW = 5'd0;
        #2;
        nvec++;
        if (hz.ForwardAE !== 2'b00) begin
            $display("FAIL fwd_both_zero got=%b exp=00", hz.ForwardAE); nerr++;
        end
        cycle();
        hz.Rs2E = 5'd9; hz.RdW = 5'd9; hz.RdM = 5'd9; hz.RegWriteM = 1'b0;
        #2;
        nvec++;
        if (hz.ForwardBE !== 2'b01) begin
            $display("FAIL fwdB_wb got=%b exp=01", hz.ForwardBE); nerr++;
        end
        nvec++;
        if (ctl !== 8'h00) begin
            $display("FAIL fwd_no_ctl got=%b exp=%b", ctl, 8'h00); nerr++;
        end
        cycle();
    endtask

    task automatic test_load_use();
        clear_inputs();
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7; hz.Rs1D = 5'd2;
        #2;
        nvec++;
        if (ctl !== 8'b1100_0100) begin
            $display("FAIL lw_stall got=%b exp=%b", ctl, 8'b1100_0100); nerr++;
        end
        cycle();
        hz.ResultSrcE = 2'b00; hz.RdE = 5'd0;
        #2;
        nvec++;
        if (ctl !== 8'h00) begin
            $display("FAIL lw_bubble got=%b exp=%b", ctl, 8'h00); nerr++;
        end
        cycle();
    endtask

    task automatic test_branch();
        clear_inputs();
        hz.PCSrcE = 1'b1;
        #2;
        nvec++;
        if (ctl !== 8'b0000_1100) begin
            $display("FAIL branch got=%b exp=%b", ctl, 8'b0000_1100); nerr++;
        end
        cycle();
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd4; hz.Rs1D = 5'd4;
        #2;
        nvec++;
        if (ctl !== 8'b1100_1100) begin
            $display("FAIL branch_lw got=%b exp=%b", ctl, 8'b1100_1100); nerr++;
        end
        cycle();
        clear_inputs();
        cycle();
    endtask

    task automatic test_timeout();
        clear_inputs();
        hz.mem_req_M = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            hz.PCSrcE = (c == 2);
            if (c == 2) begin
                hz.ResultSrcE = 2'b01; hz.RdE = 5'd8; hz.Rs1D = 5'd8;
            end else begin
                hz.ResultSrcE = 2'b00; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
            end
            #2;
            nvec++;
            if (ctl !== 8'b1111_0010) begin
                $display("FAIL to_stall c%0d got=%b exp=%b", c, ctl, 8'b1111_0010); nerr++;
            end
            cycle();
        end
        hz.PCSrcE = 1'b0; hz.ResultSrcE = 2'b00; hz.RdE = 5'd0; hz.Rs1D = 5'd0;
        #2;
        nvec++;
        if (ctl !== 8'b0000_0011) begin
            $display("FAIL to_abort got=%b exp=%b", ctl, 8'b0000_0011); nerr++;
        end
        cycle();
        #2;
        nvec++;
        if (ctl !== 8'b1111_0010) begin
            $display("FAIL to_reenter got=%b exp=%b", ctl, 8'b1111_0010); nerr++;
        end
        cycle();
        #2;
        nvec++;
        if (ctl !== 8'b1111_0010) begin
            $display("FAIL to_inwait got=%b exp=%b", ctl, 8'b1111_0010); nerr++;
        end
        cycle();
        hz.mem_req_M = 1'b0; hz.mem_ready = 1'b1;
        #2;
        nvec++;
        if (ctl !== 8'h00) begin
            $display("FAIL to_ready got=%b exp=%b", ctl, 8'h00); nerr++;
        end
        cycle();
        clear_inputs();
        cycle();
    endtask

    task automatic test_reset_mid_wait();
        clear_inputs();
        hz.mem_req_M = 1'b1;
        cycle();
        #2;
        nvec++;
        if (ctl !== 8'b1111_0010) begin
            $display("FAIL rmw_wait got=%b exp=%b", ctl, 8'b1111_0010); nerr++;
        end
        reset_n = 1'b0;
        #1;
        nvec++;
        if (ctl !== 8'h00) begin
            $display("FAIL rmw_async got=%b exp=%b", ctl, 8'h00); nerr++;
        end
        cycle();
        hz.mem_req_M = 1'b0;
        reset_n = 1'b1;
        #2;
        nvec++;
        if (ctl !== 8'h00) begin
            $display("FAIL rmw_run got=%b exp=%b", ctl, 8'h00); nerr++;
        end
        cycle();
    endtask

    task automatic test_mem_wait();
        clear_inputs();
        hz.mem_req_M = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            #2;
            nvec++;
            if (ctl !== 8'b1111_0010) begin
                $display("FAIL mw_stall c%0d got=%b exp=%b", c, ctl, 8'b1111_0010); nerr++;
            end
            cycle();
        end
        hz.mem_ready = 1'b1;
        #2;
        nvec++;
        if (ctl !== 8'h00) begin
            $display("FAIL mw_ready got=%b exp=%b", ctl, 8'h00); nerr++;
        end
        cycle();
        hz.mem_req_M = 1'b0; hz.mem_ready = 1'b0;
        #2;
        nvec++;
        if (ctl !== 8'h00) begin
            $display("FAIL mw_after got=%b exp=%b", ctl, 8'h00); nerr++;
        end
`ifdef HAZARD_PERF_EN
        nvec++;
        if ((hz.stall_cycles !== 32'd3) || (hz.flush_events !== 32'd0)) begin
            $display("FAIL perf got=%0d/%0d exp=3/0", hz.stall_cycles, hz.flush_events); nerr++;
        end
`else
        nvec++;
        if ((hz.stall_cycles !== 32'd0) || (hz.flush_events !== 32'd0)) begin
            $display("FAIL perf_off got=%0d/%0d exp=0/0", hz.stall_cycles, hz.flush_events); nerr++;
        end
`endif
        cycle();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        reset_n = 1'b0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_timeout();
        test_reset_mid_wait();
        test_mem_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core. It generates the forwarding selects, the stall enables, and the flush/clear signals consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers; FlushE drives the ID/EX `clear` input. It also contains a data-memory wait-state FSM with a timeout counter.

Parameters:
TIMEOUT, 16, max consecutive not-ready cycles tolerated for one memory access (>=2)
CNT_W, $clog2(TIMEOUT), width of the wait counter

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
Rs1D, Rs2D  in  5  source registers in ID
Rs1E, Rs2E, RdE  in  5  source/destination registers in EX
RdM, RdW  in  5  destination registers in MEM/WB
RegWriteM, RegWriteW  in  1  write-back enables in MEM/WB
ResultSrcE  in  2  EX result source; 2'b01 = load
PCSrcE  in  1  branch taken or jump in EX
mem_req_M  in  1  MEM stage performs a data-memory access
mem_ready  in  1  data memory completes the access this cycle
ForwardAE, ForwardBE  out  2  00 = regfile, 10 = ALUResultM, 01 = ResultW
StallF, StallD, StallE, StallM  out  1  hold the PC / IF-ID / ID-EX / EX-MEM register
FlushD, FlushE, FlushW  out  1  clear IF-ID / ID-EX / MEM-WB
mem_abort  out  1  one-cycle pulse on memory timeout
stall_cycles, flush_events  out  32  perf counters (see Optional Feature)

Behaviour:
- Forwarding (combinational): ForwardAE = 10 if RegWriteM && RdM!=0 && RdM==Rs1E. Else 01 if RegWriteW && RdW!=0 && RdW==Rs1E. Else 00. ForwardBE uses the same rule on Rs2E. MEM has priority over WB.
- lwStall = ResultSrcE==2'b01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states: RUN, WAIT. Reset state is RUN, wait_cnt = 0.
- memStall (Mealy): asserted in RUN when mem_req_M && !mem_ready. Asserted in WAIT when !mem_ready && !timeout.
- timeout = state==WAIT && !mem_ready && wait_cnt==TIMEOUT-1.
- RUN -> WAIT when mem_req_M && !mem_ready; wait_cnt <= 1.
- WAIT -> RUN when mem_ready; wait_cnt <= 0.
- WAIT -> RUN on timeout: mem_abort=1 and FlushW=1 for that cycle; wait_cnt <= 0.
- WAIT -> WAIT otherwise; wait_cnt increments.
- While memStall: StallF=StallD=StallE=StallM=1, FlushW=1. FlushD and FlushE are forced to 0. lwStall and PCSrcE are ignored because EX is frozen.
- While not memStall:
  - StallF = StallD = lwStall; StallE = StallM = 0.
  - FlushD = PCSrcE; FlushE = lwStall | PCSrcE.
  - FlushW = mem_abort.
- mem_req_M deasserting while in WAIT is a protocol violation; the FSM keeps waiting on mem_ready regardless.
- Asynchronous reset mid-WAIT returns to RUN immediately. Output reset values: all stalls, flushes and mem_abort = 0, ForwardAE/BE = 00, counters = 0.
- Latency: all controls are same-cycle combinational from inputs plus state. There are no registered outputs except the counters.

Optional Feature:
HAZARD_PERF_EN.
- Defined: stall_cycles increments every cycle in which StallF=1; flush_events increments every cycle in which FlushE=1. Both are 32-bit saturating at 0xFFFFFFFF and async-reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package riscv_pkg: RESULT_LOAD=2'b01; FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; state typedef {RUN, WAIT}.
- One sub-module, hazard_fwd_unit: purely combinational forwarding-select logic, instantiated once per operand or holding both selects.

Test Plan:
- RdM=5, RegWriteM=1, Rs1E=5, and RdW=5, RegWriteW=1 -> ForwardAE=10. Same with RdM=0 -> ForwardAE=01. With RdW=0 as well -> 00.
- ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle. Next cycle, with EX now a bubble (ResultSrcE=00) -> all 0.
- PCSrcE=1, no memory request -> FlushD=FlushE=1, no stalls. PCSrcE=1 together with lwStall -> FlushE=1, StallF=1.
- mem_req_M=1, mem_ready low for 3 cycles then high -> StallF..StallM=1 and FlushW=1 for 3 cycles. On the ready cycle all deassert, with no mem_abort.
- TIMEOUT=4, mem_ready held low -> stalls for cycles 1–3. Cycle 4: mem_abort=1, FlushW=1, stalls=0, state RUN. Cycle 5: mem_req_M=1 with ready low re-enters WAIT.
- reset_n pulsed low mid-WAIT -> outputs 0 asynchronously and FSM in RUN after release. With HAZARD_PERF_EN defined, after the 3-cycle wait scenario stall_cycles=3.
